// File: rtl/interrupt_sequencer_if.sv
// Handshake between the interrupt sequencer and the register-stacking unit,
// plus the handler vector handed to the fetch stage.
interface interrupt_sequencer_if;
  logic        interrupt_signal_out;
  logic        return_interrupt_signal_out;
  logic        stacking_active_in;
  logic        return_pipeline_registers_in;
  logic [63:0] vector_address_out;
  logic        vector_valid_out;

  modport master (
    output interrupt_signal_out,
    output return_interrupt_signal_out,
    output vector_address_out,
    output vector_valid_out,
    input  stacking_active_in,
    input  return_pipeline_registers_in
  );

  modport slave (
    input  interrupt_signal_out,
    input  return_interrupt_signal_out,
    input  vector_address_out,
    input  vector_valid_out,
    output stacking_active_in,
    output return_pipeline_registers_in
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Non-nesting interrupt sequencer: latches rising edges, picks the lowest enabled
// pending source and walks the stacking unit through stack, vector, service, unstack.
module interrupt_sequencer #(
  parameter int          NUM_SOURCES   = 8,
  parameter int          ID_WIDTH      = 3,
  parameter logic [63:0] VECTOR_BASE   = 64'h0000_0000_0000_0100,
  parameter int          VECTOR_SHIFT  = 3,
  parameter int          STACK_TIMEOUT = 64
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic [NUM_SOURCES-1:0] irq_enable_in,
  input  logic                   global_enable_in,
  input  logic                   mret_in,
  interrupt_sequencer_if.master  stk_if,
  output logic [ID_WIDTH-1:0]    active_id_out,
  output logic [NUM_SOURCES-1:0] pending_out,
  output logic                   busy_out,
  output logic                   error_out
);

  localparam int CNT_W = $clog2(STACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STACK_WAIT,
    SERVICE,
    UNSTACK_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] irq_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   seen_q, seen_d;
  logic                   error_q, error_d;
  logic                   int_q, int_d;
  logic                   ret_q, ret_d;
  logic                   vvld_q, vvld_d;
  logic [63:0]            vaddr_q, vaddr_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;

  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] clr_mask;
  logic [ID_WIDTH-1:0]    sel_id;

  assign eligible = pending_q & irq_enable_in;

  // Descending scan so the lowest set index is the one left in sel_id.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_id = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    error_d  = error_q;
    int_d    = 1'b0;
    vvld_d   = 1'b0;
    ret_d    = ret_q;
    vaddr_d  = vaddr_q;
    id_d     = id_q;
    clr_mask = '0;

    case (state_q)
      IDLE: begin
        if (global_enable_in && (|eligible)) begin
          id_d     = sel_id;
          clr_mask = NUM_SOURCES'(1) << sel_id;
          int_d    = 1'b1;
          cnt_d    = '0;
          seen_d   = 1'b0;
          state_d  = STACK_WAIT;
        end
      end
      STACK_WAIT: begin
        if (seen_q && !stk_if.stacking_active_in) begin
          vaddr_d = VECTOR_BASE + (64'(id_q) << VECTOR_SHIFT);
          vvld_d  = 1'b1;
          state_d = SERVICE;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (stk_if.stacking_active_in) begin
            seen_d = 1'b1;
          end
        end
      end
      SERVICE: begin
        if (mret_in) begin
          ret_d   = 1'b1;
          state_d = UNSTACK_WAIT;
        end
      end
      UNSTACK_WAIT: begin
        if (stk_if.return_pipeline_registers_in) begin
          ret_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the source being accepted must survive the clear.
    pending_d = (pending_q & ~clr_mask) | (irq_in & ~irq_prev_q);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      error_q    <= 1'b0;
      int_q      <= 1'b0;
      ret_q      <= 1'b0;
      vvld_q     <= 1'b0;
      vaddr_q    <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_in;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      error_q    <= error_d;
      int_q      <= int_d;
      ret_q      <= ret_d;
      vvld_q     <= vvld_d;
      vaddr_q    <= vaddr_d;
      id_q       <= id_d;
    end
  end

  assign stk_if.interrupt_signal_out        = int_q;
  assign stk_if.return_interrupt_signal_out = ret_q;
  assign stk_if.vector_address_out          = vaddr_q;
  assign stk_if.vector_valid_out            = vvld_q;
  assign active_id_out = id_q;
  assign pending_out   = pending_q;
  assign busy_out      = (state_q != IDLE);
  assign error_out     = error_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: expected accepts and vectors go into
// queues, and a negedge monitor pops and compares them as the DUT pulses.
module tb_interrupt_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic [7:0] irq_en;
  logic       gen;
  logic       mret;
  logic [2:0] active_id;
  logic [7:0] pending;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_id_q[$];
  logic [63:0] exp_vec_q[$];

  interrupt_sequencer_if sif();

  interrupt_sequencer dut (
    .clk_in           (clk),
    .reset_n_in       (rst_n),
    .irq_in           (irq),
    .irq_enable_in    (irq_en),
    .global_enable_in (gen),
    .mret_in          (mret),
    .stk_if           (sif),
    .active_id_out    (active_id),
    .pending_out      (pending),
    .busy_out         (busy),
    .error_out        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accept / vector pulse must match the queue head.
  always @(negedge clk) begin
    logic [2:0]  eid;
    logic [63:0] evec;
    if (rst_n) begin
      if (sif.interrupt_signal_out) begin
        if (exp_id_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept actual id=%0d required no accept", active_id);
        end else begin
          eid = exp_id_q.pop_front();
          check("accept_id", 64'(active_id), 64'(eid));
        end
      end
      if (sif.vector_valid_out) begin
        if (exp_vec_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_vector actual=%0h required no vector", sif.vector_address_out);
        end else begin
          evec = exp_vec_q.pop_front();
          check("vector_addr", sif.vector_address_out, evec);
        end
      end
    end
  end

  task automatic wait_for(input string name, input int which, input int budget);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      hit = (which == 0) ? sif.interrupt_signal_out : sif.vector_valid_out;
    end
    check(name, 64'(hit), 64'd1);
  endtask

  // From the accept negedge to the vector-valid negedge.
  task automatic stack_phase();
    @(posedge clk); #1 sif.stacking_active_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 sif.stacking_active_in = 1'b0;
    wait_for("wait_vector", 1, 10);
    check("ret_low_in_service", 64'(sif.return_interrupt_signal_out), 64'd0);
    check("busy_in_service", 64'(busy), 64'd1);
  endtask

  task automatic unstack_phase();
    @(posedge clk); #1 mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    @(negedge clk);
    check("ret_raised", 64'(sif.return_interrupt_signal_out), 64'd1);
    repeat (2) @(negedge clk);
    check("ret_held", 64'(sif.return_interrupt_signal_out), 64'd1);
    @(posedge clk); #1 sif.return_pipeline_registers_in = 1'b1;
    @(posedge clk); #1 sif.return_pipeline_registers_in = 1'b0;
    @(negedge clk);
    check("ret_dropped", 64'(sif.return_interrupt_signal_out), 64'd0);
    check("idle_after_unstack", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    irq = '0;
    irq_en = 8'hFF;
    gen = 1'b1;
    mret = 1'b0;
    sif.stacking_active_in = 1'b0;
    sif.return_pipeline_registers_in = 1'b0;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_error", 64'(err), 64'd0);
    check("rst_int", 64'(sif.interrupt_signal_out), 64'd0);
    check("rst_vaddr", sif.vector_address_out, 64'd0);
    check("rst_id", 64'(active_id), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single source 2
    exp_id_q.push_back(3'd2); exp_vec_q.push_back(64'h110);
    @(posedge clk); #1 irq[2] = 1'b1;
    wait_for("wait_accept_src2", 0, 5);
    check("busy_after_accept", 64'(busy), 64'd1);
    irq[2] = 1'b0;
    stack_phase();
    unstack_phase();

    // Priority: 1 and 5 together
    exp_id_q.push_back(3'd1); exp_vec_q.push_back(64'h108);
    exp_id_q.push_back(3'd5); exp_vec_q.push_back(64'h128);
    @(posedge clk); #1 irq[1] = 1'b1; irq[5] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("prio_pending_both", 64'(pending), 64'h22);
    irq[1] = 1'b0; irq[5] = 1'b0;
    wait_for("wait_accept_src1", 0, 3);
    check("prio_pending_after1", 64'(pending), 64'h20);
    stack_phase();
    unstack_phase();
    wait_for("wait_accept_src5", 0, 3);
    check("prio_pending_after5", 64'(pending), 64'h00);
    stack_phase();
    unstack_phase();

    // Masking on source 3
    irq_en[3] = 1'b0;
    @(posedge clk); #1 irq[3] = 1'b1;
    repeat (3) @(negedge clk);
    check("mask_pending", 64'(pending[3]), 64'd1);
    check("mask_no_accept", 64'(busy), 64'd0);
    irq[3] = 1'b0;
    exp_id_q.push_back(3'd3); exp_vec_q.push_back(64'h118);
    @(posedge clk); #1 irq_en[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mask_accept_next_cycle", 64'(sif.interrupt_signal_out), 64'd1);
    stack_phase();
    unstack_phase();

    // Stacking timeout on source 4: no vector expected
    exp_id_q.push_back(3'd4);
    @(posedge clk); #1 irq[4] = 1'b1;
    wait_for("wait_accept_src4", 0, 5);
    irq[4] = 1'b0;
    repeat (63) @(negedge clk);
    check("timeout_not_yet_err", 64'(err), 64'd0);
    check("timeout_not_yet_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_idle", 64'(busy), 64'd0);

    // Re-trigger source 0 during its own service
    exp_id_q.push_back(3'd0); exp_vec_q.push_back(64'h100);
    exp_id_q.push_back(3'd0); exp_vec_q.push_back(64'h100);
    @(posedge clk); #1 irq[0] = 1'b1;
    wait_for("wait_accept_src0", 0, 5);
    irq[0] = 1'b0;
    stack_phase();
    @(posedge clk); #1 irq[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("retrig_pending", 64'(pending[0]), 64'd1);
    irq[0] = 1'b0;
    unstack_phase();
    wait_for("wait_reaccept_src0", 0, 3);
    stack_phase();
    unstack_phase();
    @(posedge clk); #1 mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    repeat (2) @(negedge clk);
    check("spurious_mret_ret", 64'(sif.return_interrupt_signal_out), 64'd0);
    check("spurious_mret_busy", 64'(busy), 64'd0);
    check("error_sticky", 64'(err), 64'd1);

    // Async reset while waiting for unstack
    exp_id_q.push_back(3'd6); exp_vec_q.push_back(64'h130);
    @(posedge clk); #1 irq[6] = 1'b1;
    wait_for("wait_accept_src6", 0, 5);
    irq[6] = 1'b0;
    stack_phase();
    irq_en[7] = 1'b0;
    @(posedge clk); #1 irq[7] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_pending", 64'(pending), 64'h80);
    @(posedge clk); #1 mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    @(negedge clk);
    check("pre_reset_ret", 64'(sif.return_interrupt_signal_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ret", 64'(sif.return_interrupt_signal_out), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    check("arst_error", 64'(err), 64'd0);
    check("arst_vaddr", sif.vector_address_out, 64'd0);
    check("arst_id", 64'(active_id), 64'd0);
    irq = '0;
    irq_en = 8'hFF;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 64'(busy), 64'd0);
    check("exp_accepts_drained", 64'(exp_id_q.size()), 64'd0);
    check("exp_vectors_drained", 64'(exp_vec_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
